seg_scan_controller: RTL

//   Time-multiplexes NUM_DIGITS hex digits onto one shared active-low 7-segment bus and its common anodes.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/seg_scan_tick.sv | 41 ++++
 rtl/seg_scan_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller: FSM states and the
// active-low gfedcba glyph table.
package seg_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } seg_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 sits in the least-significant slot, so the list reads F down to 0.
    localparam logic [15:0][6:0] GLYPH_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return GLYPH_TAB[nib];
    endfunction

endpackage

// File: rtl/seg_scan_tick.sv
// Slot timer for the digit scan.
// Counts 0..TICK_DIV-1 while running and flags the last blank cycle and the last slot cycle.
module seg_scan_tick #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic blank_last,
    output logic slot_last
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign slot_last = (cnt_q == CW'(TICK_DIV - 1));

    if (BLANK_CYC == 0) begin : g_no_blank
        assign blank_last = 1'b0;
    end else begin : g_blank
        assign blank_last = (cnt_q == CW'(BLANK_CYC - 1));
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run || slot_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment driver with double-buffered, frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining SEG_LZ_SUPPRESS_EN.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned BLANK_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int unsigned IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    seg_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [NUM_DIGITS-1:0][3:0] disp_q, stage_q;
    logic [NUM_DIGITS-1:0]      disp_dp_q, stage_dp_q;
    logic                       stage_full_q;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q;

    logic run, blank_last, slot_last;
    logic drive, frame_end, accept, commit, suppress;

    assign run = enable_i && (state_q != OFF);

    seg_scan_tick #(
        .TICK_DIV  (TICK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .blank_last (blank_last),
        .slot_last  (slot_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF:     state_d = (BLANK_CYC == 0) ? DRIVE : BLANK;
            BLANK:   if (blank_last) state_d = DRIVE;
            DRIVE:   if (slot_last) state_d = (BLANK_CYC == 0) ? DRIVE : BLANK;
            default: state_d = OFF;
        endcase
        if (!enable_i) begin
            state_d = OFF;
        end
    end

    // Gating with enable_i darkens the very next output cycle after a disable.
    assign drive     = enable_i && (state_q == DRIVE);
    assign frame_end = drive && slot_last && (idx_q == LAST_IDX);
    assign accept    = upd_valid && !stage_full_q;
    assign commit    = stage_full_q && ((state_q == OFF) || frame_end);
    assign upd_ready = !stage_full_q;

    always_comb begin
        idx_d = idx_q;
        if (!enable_i) begin
            idx_d = '0;
        end else if (drive && slot_last) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

`ifdef SEG_LZ_SUPPRESS_EN
    logic [IW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            if (disp_q[k] != 4'h0) msd = IW'(k);
        end
    end

    // Digit 0 can never exceed msd, so it is always shown.
    assign suppress = (idx_q > msd);
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        an_d  = '1;
        if (drive) begin
            an_d[idx_q] = 1'b0;
            seg_d       = suppress ? SEG_BLANK : hex_glyph(disp_q[idx_q]);
            dp_d        = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= OFF;
            idx_q        <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            stage_q      <= '0;
            stage_dp_q   <= '0;
            stage_full_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_end;
            if (commit) begin
                disp_q       <= stage_q;
                disp_dp_q    <= stage_dp_q;
                stage_full_q <= 1'b0;
            end else if (accept) begin
                stage_q      <= value_i;
                stage_dp_q   <= dp_i;
                stage_full_q <= 1'b1;
            end
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule
